// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, branch redirect,
// IF/ID pipeline register and saturating stall/flush debug counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Block_PC_Write,
    input  logic                 Block_IF_ID_Write,
    input  logic                 Flush,
    input  logic [31:0]          Branch_Target,
    input  logic [31:0]          Instr_Mem_Data,
    output logic [31:0]          Instr_Mem_Addr,
    output logic [31:0]          IF_ID_Instruction,
    output logic [31:0]          IF_ID_PC_Plus_4,
    output logic                 IF_ID_Valid,
    output logic [CNT_WIDTH-1:0] Stall_Count,
    output logic [CNT_WIDTH-1:0] Flush_Count
);

    logic [31:0]          pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          pc4_q, pc4_d;
    logic                 vld_q, vld_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]          pc_plus_4;

    // Wraps naturally modulo 2^32.
    assign pc_plus_4 = pc_q + 32'd4;

    // Next-state: flush beats both blocks; blocks act independently.
    always_comb begin
        pc_d        = pc_plus_4;
        instr_d     = Instr_Mem_Data;
        pc4_d       = pc_plus_4;
        vld_d       = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (Flush) begin
            pc_d    = {Branch_Target[31:2], 2'b00};
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            vld_d   = 1'b0;
        end else begin
            if (Block_PC_Write) pc_d = pc_q;
            if (Block_IF_ID_Write) begin
                instr_d = instr_q;
                pc4_d   = pc4_q;
                vld_d   = vld_q;
            end
        end

        // Counters stick at all-ones rather than wrapping.
        if (Block_IF_ID_Write && !Flush && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (Flush && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State registers; synchronous reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= {RESET_PC[31:2], 2'b00};
            instr_q     <= 32'd0;
            pc4_q       <= 32'd0;
            vld_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Instr_Mem_Addr    = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PC_Plus_4   = pc4_q;
    assign IF_ID_Valid       = vld_q;
    assign Stall_Count       = stall_cnt_q;
    assign Flush_Count       = flush_cnt_q;

endmodule
